// File: rtl/harness_pkg.sv
// Shared definitions for the RAM2 preload harness: sequencer state encoding
// and the default RAM2 geometry used by both the sequencer and the memory.
package harness_pkg;

  localparam int RAM2_ADDR_W = 5;
  localparam int RAM2_DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_READ,
    S_DONE,
    S_FAIL
  } seq_state_t;

  // Kernel is held in reset whenever RAM2 may still be changing under it.
  function automatic logic kern_held(input seq_state_t s);
    return (s == S_IDLE) || (s == S_LOAD) || (s == S_RELEASE) || (s == S_FAIL);
  endfunction

  function automatic logic seq_busy(input seq_state_t s);
    return (s == S_LOAD) || (s == S_RELEASE) || (s == S_RUN) || (s == S_READ);
  endfunction

endpackage

// File: rtl/ram_preload_seq.sv
// Preload RAM2 through its debug write port, run the kernel with a timeout,
// then stream a result window back out through the debug read port.
module ram_preload_seq
  import harness_pkg::*;
#(
  parameter int ADDR_W  = RAM2_ADDR_W,
  parameter int DATA_W  = RAM2_DATA_W,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_count,
  output logic              dbg_wr_en,
  output logic [ADDR_W-1:0] dbg_wr_addr,
  output logic [DATA_W-1:0] dbg_wr_data,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              kern_rst,
  input  logic              kern_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              fail
);

  localparam logic [CNT_W-1:0]  RUN_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WORD_ONE = (ADDR_W + 1)'(1);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [ADDR_W-1:0] rd_base_q;
  logic [ADDR_W:0]   rd_count_q;
  logic [ADDR_W:0]   words_left;
  logic [CNT_W-1:0]  run_cnt;

  logic in_fire;
  logic out_fire;
  logic start_ok;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign start_ok = start & ((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));
  assign out_data = dbg_data;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_FAIL: if (start_ok) state_nxt = S_LOAD;
      S_LOAD:                 if (in_fire && in_last) state_nxt = S_RELEASE;
      S_RELEASE:              state_nxt = S_RUN;
      S_RUN: begin
        // A valid arriving on the timeout cycle still counts as success.
        if (kern_valid)             state_nxt = S_READ;
        else if (run_cnt == RUN_LAST) state_nxt = S_FAIL;
      end
      S_READ: begin
        if (!out_valid)                           state_nxt = S_DONE;
        else if (out_ready && words_left == WORD_ONE) state_nxt = S_DONE;
      end
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      kern_rst    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      out_valid   <= 1'b0;
      dbg_wr_en   <= 1'b0;
      dbg_wr_addr <= '0;
      dbg_wr_data <= '0;
      dbg_addr    <= '0;
      rd_base_q   <= '0;
      rd_count_q  <= '0;
      words_left  <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == S_LOAD);
      kern_rst  <= kern_held(state_nxt);
      busy      <= seq_busy(state_nxt);
      done      <= (state_nxt == S_DONE);
      fail      <= (state_nxt == S_FAIL);
      dbg_wr_en <= in_fire;
      if (in_fire) begin
        dbg_wr_addr <= in_addr;
        dbg_wr_data <= in_data;
      end
      if (start_ok) begin
        rd_base_q  <= rd_base;
        rd_count_q <= rd_count;
      end
      // The read address is loaded on READ entry so dbg_data is ready in the first READ cycle.
      if (state == S_RUN && state_nxt == S_READ) begin
        dbg_addr   <= rd_base_q;
        words_left <= rd_count_q;
      end else if (state == S_READ && out_fire) begin
        dbg_addr   <= dbg_addr + ADDR_ONE;
        words_left <= words_left - WORD_ONE;
      end
      out_valid <= (state_nxt == S_READ) &&
                   ((state == S_READ) ? out_valid : (rd_count_q != '0));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt <= '0;
    end else if (start_ok) begin
      run_cnt <= '0;
    end else if (state == S_RUN) begin
      run_cnt <= run_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_ram_preload_seq.sv
// Directed bench for ram_preload_seq with a behavioural RAM2 and a scripted kernel.
module tb_ram_preload_seq;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic [ADDR_W-1:0] rd_base = '0;
  logic [ADDR_W:0]   rd_count = '0;
  logic              dbg_wr_en;
  logic [ADDR_W-1:0] dbg_wr_addr;
  logic [DATA_W-1:0] dbg_wr_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              kern_rst;
  logic              kern_valid = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic              fail;
  logic              kern_copy = 1'b0;

  logic [DATA_W-1:0] mem [32];

  int tests = 0;
  int fails = 0;

  ram_preload_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data), .in_last(in_last),
    .rd_base(rd_base), .rd_count(rd_count),
    .dbg_wr_en(dbg_wr_en), .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .kern_rst(kern_rst), .kern_valid(kern_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  // RAM2 model: synchronous debug write, combinational debug read; the kernel copies a[2] to a[3].
  always @(posedge clk) begin
    if (dbg_wr_en) mem[dbg_wr_addr] <= dbg_wr_data;
    if (kern_copy) mem[3] <= mem[2];
  end
  assign dbg_data = mem[dbg_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] cnt);
    rd_base  = base;
    rd_count = cnt;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic send_beat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic last);
    int waited;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    while (!in_ready && waited < 8) begin
      step();
      waited++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL beat_ready_timeout: in_ready got %0b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    tests++; if (kern_rst !== 1'b1) begin fails++; $display("[TB] FAIL reset_kern_rst: got %0b want 1", kern_rst); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready: got %0b want 0", in_ready); end
    tests++; if ({busy, done, fail, out_valid, dbg_wr_en} !== 5'b0) begin
      fails++; $display("[TB] FAIL reset_flags: got %05b want 00000", {busy, done, fail, out_valid, dbg_wr_en});
    end
    tests++; if (dbg_addr !== 5'd0 || dbg_wr_addr !== 5'd0 || dbg_wr_data !== 32'd0) begin
      fails++; $display("[TB] FAIL reset_addr: got %0h/%0h/%0h want 0/0/0", dbg_addr, dbg_wr_addr, dbg_wr_data);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    do_start(5'd3, 6'd1);
    tests++; if (in_ready !== 1'b1 || busy !== 1'b1 || kern_rst !== 1'b1) begin
      fails++; $display("[TB] FAIL basic_load: got ready/busy/krst %0b%0b%0b want 111", in_ready, busy, kern_rst);
    end
    send_beat(5'd2, 32'd34, 1'b1);
    tests++; if (in_ready !== 1'b0 || kern_rst !== 1'b1 || dbg_wr_en !== 1'b1) begin
      fails++; $display("[TB] FAIL basic_release: got ready/krst/wr %0b%0b%0b want 011", in_ready, kern_rst, dbg_wr_en);
    end
    step();
    tests++; if (kern_rst !== 1'b0) begin fails++; $display("[TB] FAIL basic_run_kern_rst: got %0b want 0", kern_rst); end
    kern_copy = 1'b1;
    step();
    kern_copy  = 1'b0;
    kern_valid = 1'b1;
    step();
    kern_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 32'd34 || dbg_addr !== 5'd3) begin
      fails++; $display("[TB] FAIL basic_read: got v=%0b d=%0d a=%0d want v=1 d=34 a=3", out_valid, out_data, dbg_addr);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++; if (done !== 1'b1 || fail !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL basic_done: got done/fail/v/busy %0b%0b%0b%0b want 1000", done, fail, out_valid, busy);
    end
  endtask

  task automatic test_timeout();
    do_start(5'd0, 6'd1);
    send_beat(5'd4, 32'd9, 1'b1);
    step();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    tests++; if (fail !== 1'b0 || busy !== 1'b1 || kern_rst !== 1'b0) begin
      fails++; $display("[TB] FAIL timeout_early: got fail/busy/krst %0b%0b%0b want 010", fail, busy, kern_rst);
    end
    step();
    tests++; if (fail !== 1'b1 || kern_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("[TB] FAIL timeout_fail: got fail/krst/busy/done %0b%0b%0b%0b want 1100", fail, kern_rst, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] expv [4];
    int idx;
    logic r;
    expv[0] = 32'd1; expv[1] = 32'd2; expv[2] = 32'd3; expv[3] = 32'd4;
    do_start(5'd0, 6'd4);
    for (int i = 0; i < 4; i++) begin
      send_beat(5'(i), 32'(i + 1), (i == 3));
      tests++; if (dbg_wr_en !== 1'b1 || dbg_wr_addr !== 5'(i) || dbg_wr_data !== 32'(i + 1)) begin
        fails++; $display("[TB] FAIL b2b_write%0d: got en=%0b a=%0d d=%0d want en=1 a=%0d d=%0d",
                          i, dbg_wr_en, dbg_wr_addr, dbg_wr_data, i, i + 1);
      end
    end
    step();
    kern_valid = 1'b1;
    step();
    kern_valid = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      r = 1'b0;
      if (out_valid) begin
        if (idx > 3) begin
          tests++; fails++;
          $display("[TB] FAIL b2b_extra_beat: got out_valid=1 after %0d beats want 0", idx);
        end else begin
          tests++; if (out_data !== expv[idx] || dbg_addr !== 5'(idx)) begin
            fails++; $display("[TB] FAIL b2b_data%0d: got d=%0d a=%0d want d=%0d a=%0d",
                              idx, out_data, dbg_addr, expv[idx], idx);
          end
        end
        r = ((cyc % 3) != 1);
        if (r) idx++;
      end
      out_ready = r;
      step();
    end
    out_ready = 1'b0;
    tests++; if (idx !== 4 || done !== 1'b1) begin
      fails++; $display("[TB] FAIL b2b_count: got beats=%0d done=%0b want beats=4 done=1", idx, done);
    end
  endtask

  task automatic test_wrap();
    do_start(5'd31, 6'd2);
    send_beat(5'd31, 32'hDEAD_0031, 1'b0);
    send_beat(5'd0, 32'h1234_0000, 1'b1);
    step();
    kern_valid = 1'b1;
    step();
    kern_valid = 1'b0;
    tests++; if (dbg_addr !== 5'd31 || out_data !== 32'hDEAD_0031 || out_valid !== 1'b1) begin
      fails++; $display("[TB] FAIL wrap_first: got a=%0d d=%0h v=%0b want a=31 d=dead0031 v=1", dbg_addr, out_data, out_valid);
    end
    out_ready = 1'b1;
    step();
    tests++; if (dbg_addr !== 5'd0 || out_data !== 32'h1234_0000 || out_valid !== 1'b1) begin
      fails++; $display("[TB] FAIL wrap_second: got a=%0d d=%0h v=%0b want a=0 d=12340000 v=1", dbg_addr, out_data, out_valid);
    end
    step();
    out_ready = 1'b0;
    tests++; if (done !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL wrap_done: got done=%0b v=%0b want done=1 v=0", done, out_valid);
    end
  endtask

  task automatic test_reset_mid_load();
    do_start(5'd5, 6'd1);
    send_beat(5'd5, 32'd55, 1'b0);
    step();
    rst = 1'b0;
    #2;
    tests++; if (kern_rst !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || dbg_wr_en !== 1'b0) begin
      fails++; $display("[TB] FAIL midrst_async: got krst/ready/busy/wr %0b%0b%0b%0b want 1000", kern_rst, in_ready, busy, dbg_wr_en);
    end
    step();
    tests++; if ({done, fail, out_valid} !== 3'b0 || dbg_wr_addr !== 5'd0 || dbg_addr !== 5'd0) begin
      fails++; $display("[TB] FAIL midrst_state: got flags=%03b wa=%0d a=%0d want 000/0/0", {done, fail, out_valid}, dbg_wr_addr, dbg_addr);
    end
    rst = 1'b1;
    step();
    tests++; if (mem[5] !== 32'd55) begin
      fails++; $display("[TB] FAIL midrst_partial_kept: got %0d want 55", mem[5]);
    end
    do_start(5'd5, 6'd1);
    send_beat(5'd7, 32'd77, 1'b1);
    step();
    kern_valid = 1'b1;
    step();
    kern_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 32'd55) begin
      fails++; $display("[TB] FAIL midrst_restart_read: got v=%0b d=%0d want v=1 d=55", out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL midrst_restart_done: got %0b want 1", done); end
  endtask

  task automatic test_zero_count();
    do_start(5'd0, 6'd0);
    send_beat(5'd9, 32'd99, 1'b1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    tests++; if (busy !== 1'b1 || kern_rst !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL zero_start_ignored: got busy/krst/ready %0b%0b%0b want 100", busy, kern_rst, in_ready);
    end
    kern_valid = 1'b1;
    step();
    kern_valid = 1'b0;
    tests++; if (out_valid !== 1'b0 || done !== 1'b0) begin
      fails++; $display("[TB] FAIL zero_read: got v=%0b done=%0b want v=0 done=0", out_valid, done);
    end
    step();
    tests++; if (done !== 1'b1 || out_valid !== 1'b0 || fail !== 1'b0) begin
      fails++; $display("[TB] FAIL zero_done: got done/v/fail %0b%0b%0b want 100", done, out_valid, fail);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_back_to_back();
    test_wrap();
    test_reset_mid_load();
    test_zero_count();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
